// File: rtl/uart_slave_client_if.sv
// rtl/uart_slave_client_if.sv - slave-port bus and byte-stream signals of uart_slave_client
interface uart_slave_client_if;
  logic       o_bus_cs;
  logic       o_bus_we;
  logic       o_bus_addr;
  logic [7:0] o_bus_dat;
  logic [7:0] i_bus_dat;
  logic       i_bus_ack;
  logic [7:0] o_rx_dat;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic [7:0] i_tx_dat;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [3:0] o_status;
  logic       o_err;

  // client side: drives the slave port, sources rx bytes, sinks tx bytes
  modport master (
    output o_bus_cs, o_bus_we, o_bus_addr, o_bus_dat,
    input  i_bus_dat, i_bus_ack,
    output o_rx_dat, o_rx_valid,
    input  i_rx_ready,
    input  i_tx_dat, i_tx_valid,
    output o_tx_ready, o_status, o_err
  );

  // environment side: UART slave port plus stream producer/consumer
  modport slave (
    input  o_bus_cs, o_bus_we, o_bus_addr, o_bus_dat,
    output i_bus_dat, i_bus_ack,
    input  o_rx_dat, o_rx_valid,
    output i_rx_ready,
    output i_tx_dat, i_tx_valid,
    input  o_tx_ready, o_status, o_err
  );
endinterface

// File: rtl/uart_slave_client.sv
// rtl/uart_slave_client.sv - polling bus master moving bytes between a UART slave port and rx/tx streams
module uart_slave_client #(
  parameter int TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  uart_slave_client_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_GAP    = 3'd0,
    S_STATUS = 3'd1,
    S_DECIDE = 3'd2,
    S_WRITE  = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_cs;
  logic          r_we;
  logic          r_addr;
  logic [7:0]    r_dat_out;
  logic [7:0]    r_tx_hold;
  logic          r_tx_full;
  logic [7:0]    r_rx_hold;
  logic          r_rx_valid;
  logic [3:0]    r_status;   // {tx_full, tx_empty, rx_full, rx_empty}
  logic          r_err;
  logic          r_last_tx;  // 1 = tx served last, 0 = rx served last
  logic [CW-1:0] r_cnt;

  logic w_tx_accept;
  logic w_rx_consume;
  logic w_tx_elig;
  logic w_rx_elig;
  logic w_pick_tx;
  logic w_cnt_last;

  assign w_tx_accept  = bus.i_tx_valid && !r_tx_full;
  assign w_rx_consume = r_rx_valid && bus.i_rx_ready;
  assign w_tx_elig    = r_tx_full && !r_status[3];
  assign w_rx_elig    = !r_rx_valid && !r_status[0];
  // tx wins when it is the only candidate, or when both are and rx went last
  assign w_pick_tx    = w_tx_elig && (!w_rx_elig || !r_last_tx);
  assign w_cnt_last   = (r_cnt == CW'(TIMEOUT - 1));

  assign bus.o_bus_cs   = r_cs;
  assign bus.o_bus_we   = r_we;
  assign bus.o_bus_addr = r_addr;
  assign bus.o_bus_dat  = r_dat_out;
  assign bus.o_rx_dat   = r_rx_hold;
  assign bus.o_rx_valid = r_rx_valid;
  assign bus.o_tx_ready = !r_tx_full;
  assign bus.o_status   = r_status;
  assign bus.o_err      = r_err;

  // poll/access sequencer together with the stream holding registers it shares flags with
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_GAP;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 1'b0;
      r_dat_out  <= 8'h00;
      r_tx_hold  <= 8'h00;
      r_tx_full  <= 1'b0;
      r_rx_hold  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_status   <= 4'b0101;
      r_err      <= 1'b0;
      r_last_tx  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_err <= 1'b0;
      // WRITE clears tx_full only while full and READ sets rx_valid only while
      // empty, so these stream updates never collide with the bus updates below
      if (w_tx_accept) begin
        r_tx_hold <= bus.i_tx_dat;
        r_tx_full <= 1'b1;
      end
      if (w_rx_consume) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        S_GAP: begin
          r_cs    <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_STATUS;
        end
        S_DECIDE: begin
          if (w_tx_elig || w_rx_elig) begin
            r_cs      <= 1'b1;
            r_addr    <= 1'b1;
            r_we      <= w_pick_tx;
            r_cnt     <= '0;
            r_last_tx <= w_pick_tx;
            if (w_pick_tx) begin
              r_dat_out <= r_tx_hold;
              r_state   <= S_WRITE;
            end else begin
              r_state   <= S_READ;
            end
          end else begin
            r_state <= S_GAP;
          end
        end
        S_STATUS, S_WRITE, S_READ: begin
          if (bus.i_bus_ack) begin
            // cs held through the ack cycle; the slave's trailing ack falls into GAP/DECIDE
            r_cs   <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= 1'b0;
            case (r_state)
              S_STATUS: r_status <= bus.i_bus_dat[3:0];
              S_WRITE:  r_tx_full <= 1'b0;
              S_READ: begin
                r_rx_hold  <= bus.i_bus_dat;
                r_rx_valid <= 1'b1;
              end
              default: ;
            endcase
            r_state <= (r_state == S_STATUS) ? S_DECIDE : S_GAP;
          end else if (w_cnt_last) begin
            // abandon the access; holding registers stay as they are so a write retries
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cs    <= 1'b0;
          r_state <= S_GAP;
        end
      endcase
    end
  end

endmodule
